// File: rtl/dds_pkg.sv
// Shared encodings and widths for the DDS output chain.
package dds_pkg;
  localparam int ADDR_W = 6;
  localparam int DAC_W  = 8;
  localparam logic [DAC_W-1:0] DAC_MID = 8'h80;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  typedef struct packed {
    wave_e      sel;
    logic [7:0] amp;
  } cfg_t;
endpackage

// File: rtl/dds_sine_qrom.sv
// Quarter-wave sine magnitude: round(127*sin(2*pi*j/64)) for j = 0..16.
module dds_sine_qrom (
  input  logic [4:0] idx_i,
  output logic [6:0] mag_o
);
  always_comb begin
    mag_o = 7'd0;
    case (idx_i)
      5'd0:  mag_o = 7'd0;
      5'd1:  mag_o = 7'd12;
      5'd2:  mag_o = 7'd25;
      5'd3:  mag_o = 7'd37;
      5'd4:  mag_o = 7'd49;
      5'd5:  mag_o = 7'd60;
      5'd6:  mag_o = 7'd71;
      5'd7:  mag_o = 7'd81;
      5'd8:  mag_o = 7'd90;
      5'd9:  mag_o = 7'd98;
      5'd10: mag_o = 7'd106;
      5'd11: mag_o = 7'd112;
      5'd12: mag_o = 7'd117;
      5'd13: mag_o = 7'd122;
      5'd14: mag_o = 7'd125;
      5'd15: mag_o = 7'd126;
      5'd16: mag_o = 7'd127;
      default: mag_o = 7'd0;
    endcase
  end
endmodule

// File: rtl/dds_wave_shaper.sv
// Phase address -> waveform -> amplitude scale -> offset-binary DAC word.
// Three-stage pipe; config changes are latched at a phase wrap (or while disabled).
module dds_wave_shaper
  import dds_pkg::*;
#(
  parameter bit SYNC_UPDATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              en_i,
  input  logic [1:0]        wave_sel_i,
  input  logic [7:0]        amp_i,
  output logic [DAC_W-1:0]  dac_out_o,
  output logic              out_valid_o
);
  localparam int STAGES = 3;

  logic [STAGES:0]   vld_pipe_q;
  logic [ADDR_W-1:0] addr0_q;
  cfg_t              cfg_q, cfg_d;
  logic              wrap;

  logic [4:0]        rom_idx;
  logic [6:0]        rom_mag;
  logic [7:0]        sine_mag, s_d, s1_q;
  logic [7:0]        amp1_q;
  logic signed [16:0] prod;
  logic [7:0]        y2_q;
  logic [DAC_W-1:0]  dac_q;

  // addr0_q doubles as prev_addr: the incoming addr is compared with the last
  // registered one, so the wrapped sample itself is the first to see the new config.
  assign wrap = addr_i < addr0_q;

  always_comb begin
    cfg_d = cfg_q;
    if (!SYNC_UPDATE || wrap || !en_i) cfg_d = '{sel: wave_e'(wave_sel_i), amp: amp_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      addr0_q    <= '0;
      cfg_q      <= '{sel: WAVE_SINE, amp: 8'd0};
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], en_i};
      addr0_q    <= addr_i;
      cfg_q      <= cfg_d;
    end
  end

  // Odd quadrants read the table backwards; the upper half negates.
  assign rom_idx  = addr0_q[4] ? (5'd16 - {1'b0, addr0_q[3:0]}) : {1'b0, addr0_q[3:0]};
  assign sine_mag = {1'b0, rom_mag};

  dds_sine_qrom u_qrom (
    .idx_i (rom_idx),
    .mag_o (rom_mag)
  );

  always_comb begin
    s_d = '0;
    case (cfg_q.sel)
      WAVE_SINE:   s_d = addr0_q[5] ? -sine_mag : sine_mag;
      WAVE_SQUARE: s_d = addr0_q[5] ? 8'h81 : 8'h7F;
      WAVE_TRI:    s_d = addr0_q[5] ? (8'd127 - {addr0_q[4:0], 3'b000})
                                    : ({addr0_q[4:0], 3'b000} ^ DAC_MID);
      WAVE_SAW:    s_d = {addr0_q, 2'b00} ^ DAC_MID;
      default:     s_d = '0;
    endcase
  end

  assign prod = $signed(s1_q) * $signed({1'b0, amp1_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      amp1_q <= '0;
      y2_q   <= '0;
      dac_q  <= DAC_MID;
    end else begin
      s1_q   <= vld_pipe_q[0] ? s_d : 8'd0;
      amp1_q <= cfg_q.amp;
      y2_q   <= prod[15:8];
      dac_q  <= y2_q ^ DAC_MID;
    end
  end

  assign dac_out_o   = dac_q;
  assign out_valid_o = vld_pipe_q[STAGES];
endmodule

// File: doc/dds_wave_shaper.md
# dds_wave_shaper

Downstream stage of the DDS phase accumulator. Takes the 6-bit phase address produced each clock, maps it through a waveform generator (quarter-wave sine table, square, triangle, sawtooth), applies an 8-bit amplitude scale, and drives an 8-bit offset-binary DAC word. Waveform and amplitude changes are applied only at a phase wrap, so every output period is glitch-free.

## Interface
- SYNC_UPDATE, 1, 1: wave_sel/amp take effect only at a phase wrap or while en=0; 0: take effect on the next clock.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- addr  in  6  phase address from the accumulator, new value every clock
- en  in  1  output enable; 0 forces midscale
- wave_sel  in  2  pending waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth
- amp  in  8  pending amplitude, unsigned, 0 = silent
- dac_out  out  8  offset-binary DAC sample
- out_valid  out  1  en delayed to align with dac_out

## Operation
- Stage 0 registers addr, en, prev_addr and the active config (act_sel, act_amp).
- Wrap: addr < prev_addr, both as registered samples. This detects a wrap even when the step skips address 0.
- Config load (SYNC_UPDATE=1): act_sel/act_amp load from the inputs when wrap=1 or en=0. Otherwise they hold.
- Stage 1 computes the signed 8-bit sample s from act_sel and addr n, with q=n[5:4] and k=n[3:0]:
  - Sine: Q[j]=round(127*sin(2*pi*j/64)), j=0..16, stored in a 17-entry ROM. q0: +Q[k]; q1: +Q[16-k]; q2: -Q[k]; q3: -Q[16-k]. Key entries: Q[0]=0, Q[4]=49, Q[8]=90, Q[16]=127.
  - Square: n<32 gives +127, else -127.
  - Triangle: n<32 gives -128+8n; n>=32 gives 127-8(n-32).
  - Sawtooth: -128+4n.
- Stage 2 computes p=(s*act_amp), 16-bit signed, then y = p>>>8 (arithmetic shift, floor). y is always within [-128,127] and no saturation is needed.
- Stage 3 outputs dac_out = y XOR 8'h80, which is offset binary.
- en=0 at stage 0 forces y=0 through the pipe, so dac_out=128 and out_valid=0.
- act_sel/act_amp travel with their sample down the pipe. A config change never mixes with an old sample.

## Timing
- Latency is 3 clocks: an addr sampled at edge k appears on dac_out after edge k+3. Throughput is one sample per clock.
- Reset values:
  - dac_out=8'h80, out_valid=0
  - prev_addr=0, act_sel=0 (sine), act_amp=0
  - all pipeline registers 0 or midscale
- After reset deassert with en=1, output stays 128 until the first wrap loads amp. If en=0 the config loads immediately.
- Wrap and config change on the same clock: the new config applies to the post-wrap sample, which is the one where addr < prev_addr.
- addr held constant (step 0): no wrap occurs and the config stays frozen while en=1.
- Reset mid-stream clears the pipe in the same cycle, asynchronously. The first valid output comes 3 clocks after the first en=1 edge.
- SYNC_UPDATE=0: the config is registered at stage 0 every clock, and latency is unchanged.

## Structure
- Shared package (dds_pkg): the wave_sel encodings (WAVE_SINE, WAVE_SQUARE, WAVE_TRI, WAVE_SAW), ADDR_W=6, DAC_W=8, DAC_MID=8'h80.
- One sub-module, dds_sine_qrom: a 17-entry by 7-bit combinational quarter-sine ROM, indexed 0..16.
- Mirror/sign logic, the other waveforms, the multiplier and the pipeline live in dds_wave_shaper.

## Test plan
- Sine, amp=255, en=1, addr stepping by 1, after the first wrap:
  - addr 0 → 128, addr 16 → 254, addr 32 → 128, addr 48 → 1
  - each value appears 3 clocks after its addr
- Sine, amp=128:
  - addr 16 → 191 (127*128>>8 = 63)
  - addr 8 → 173 (90*128>>8 = 45)
- Change wave_sel to square mid-period (addr 20), stepping by 1:
  - sine continues through addr 63
  - the first square sample follows the wrap: addr 0 → 254
- Step 7, so addr sequence 56, 63, 6: wrap is detected at 6 even though 0 is skipped, and the pending config loads there.
- en=0 for 5 clocks, then en=1:
  - dac_out is 128 and out_valid=0 until 3 clocks after en rises
  - config applied while en=0 is in effect immediately
- Async reset asserted mid-stream:
  - dac_out=128 and out_valid=0 in the same cycle
  - after release, act_amp=0, so the output stays 128 until the first wrap
